// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//
// Loadable down-counting timer. A start strobe loads a count N and the timer
// counts N, N-1, ..., 0, pulsing o_cnt_done on the cycle the count shows 0.
// In loop mode it reloads N on the following cycle (period N+1). Supports
// pause (level), stop (abort) and retrigger, and keeps a saturating tally of
// expiries since the last accepted start.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active-high
//   i_load_val  count value N, sampled on an accepted start
//   i_start     start / retrigger strobe
//   i_loop      auto-reload mode, sampled with i_start
//   i_pause     level, freezes the count while high (RUN only)
//   i_stop      abort strobe, highest priority
//   o_busy      high in RUN or PAUSE
//   o_paused    high in PAUSE
//   o_cnt_done  one-cycle expiry pulse, coincident with o_cnt_val == 0
//   o_cnt_val   current count
//   o_exp_cnt   expiries since last accepted start, saturating
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_start,
    input  logic                 i_loop,
    input  logic                 i_pause,
    input  logic                 i_stop,
    output logic                 o_busy,
    output logic                 o_paused,
    output logic                 o_cnt_done,
    output logic [CNT_WIDTH-1:0] o_cnt_val,
    output logic [EXP_WIDTH-1:0] o_exp_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_WIDTH-1:0]   cnt_q,    cnt_d;
    logic [CNT_WIDTH-1:0]   reload_q, reload_d;
    logic                   loop_q,   loop_d;
    logic                   done_q,   done_d;
    logic                   busy_q,   busy_d;
    logic                   paused_q, paused_d;
    logic [EXP_WIDTH-1:0]   exp_q,    exp_d;

    // Tally holds at all-ones instead of wrapping.
    function automatic logic [EXP_WIDTH-1:0] sat_inc(input logic [EXP_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        exp_d    = exp_q;

        if (i_stop) begin
            // Abort: no expiry, tally retained.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (i_start) begin
            reload_d = i_load_val;
            loop_d   = i_loop;
            if (i_load_val == '0) begin
                // Zero load expires immediately without ever entering RUN.
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                exp_d   = EXP_WIDTH'(1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = i_load_val;
                exp_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN, ST_PAUSE: begin
                    if (i_pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        // Leaving PAUSE takes a normal RUN step in the same
                        // cycle, so the hold adds exactly the pause length.
                        state_d = ST_RUN;
                        if (cnt_q == '0) begin
                            if (loop_q) begin
                                cnt_d = reload_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                            // Done is registered alongside the count reaching 0.
                            if (cnt_q == CNT_WIDTH'(1)) begin
                                done_d = 1'b1;
                                exp_d  = sat_inc(exp_q);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d   = (state_d != ST_IDLE);
        paused_d = (state_d == ST_PAUSE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
            exp_q    <= exp_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_paused   = paused_q;
    assign o_cnt_done = done_q;
    assign o_cnt_val  = cnt_q;
    assign o_exp_cnt  = exp_q;

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, programmable down-counting timer; the countdown counterpart of the free-running up counter.
- A controller loads a count value and starts the timer. The block counts to zero and raises a one-cycle expiry pulse, in one-shot or auto-reload mode.
- Supports pause, stop and retrigger, and keeps a saturating expiry tally for status reads.
- Sits between control FSMs (timeouts, baud/tick generation) and the datapath.

Parameters:
- CNT_WIDTH, 16, width of load value and counter.
- EXP_WIDTH, 8, width of saturating expiry tally.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_load_val  input  CNT_WIDTH  count value, sampled when a start is accepted.
- i_start  input  1  start/retrigger strobe.
- i_loop  input  1  auto-reload mode, sampled with i_start.
- i_pause  input  1  level; holds count while high.
- i_stop  input  1  abort strobe.
- o_busy  output  1  high in RUN or PAUSE.
- o_paused  output  1  high in PAUSE.
- o_cnt_done  output  1  one-cycle expiry pulse.
- o_cnt_val  output  CNT_WIDTH  current count.
- o_exp_cnt  output  EXP_WIDTH  expiries since last accepted start, saturating.

Behaviour:
- Reset (i_rst high at an edge):
  - State IDLE.
  - o_cnt_val=0, o_cnt_done=0, o_busy=0, o_paused=0, o_exp_cnt=0.
  - Internal reload register=0, loop flag=0.
  - Reset overrides all inputs, including mid-count.
- All outputs are registered. Control priority: i_stop > i_start > i_pause.
- States: IDLE, RUN, PAUSE.
- Accepted start (i_start=1, i_stop=0, any state):
  - Latches i_load_val into reload register and counter, and i_loop into loop flag.
  - Clears o_exp_cnt.
  - Next cycle: RUN, o_cnt_val=N, o_busy=1.
  - Start in RUN/PAUSE is a retrigger with the same effect.
- Zero load (N=0):
  - No RUN. o_cnt_done=1 and o_exp_cnt=1 the cycle after start.
  - State IDLE, o_busy stays 0, loop flag ignored.
- RUN:
  - Counter decrements by 1 per cycle: N, N-1, ..., 0.
  - o_cnt_done=1 in the same cycle o_cnt_val==0, i.e. N cycles after o_cnt_val first shows N. o_exp_cnt increments that same cycle, saturating at 2^EXP_WIDTH-1.
  - Loop=1: cycle after 0, o_cnt_val=N again, remains RUN. Period N+1 cycles, done pulses exactly N+1 apart.
  - Loop=0: cycle after done, state IDLE, o_busy=0, o_cnt_val stays 0.
- Pause:
  - i_pause=1 in RUN (no stop/start): next cycle PAUSE, o_paused=1, count frozen.
  - Decrement resumes the cycle after i_pause falls, with no skipped or repeated values beyond the hold.
  - Pause while o_cnt_val==0 in loop mode holds at 0. o_cnt_done is not re-pulsed; reload occurs on the first cycle after resume.
  - i_pause in IDLE: ignored.
- Stop:
  - i_stop=1 in any state: next cycle IDLE, o_cnt_val=0, o_busy=0, o_paused=0.
  - No done pulse. o_exp_cnt held.
  - Stop with simultaneous start: stop wins, start discarded.
- Width rules:
  - Counter never underflows; 0 is the terminal value.
  - N = 2^CNT_WIDTH-1 is legal.
  - Tally saturates, never wraps.

Test Plan:
- Reset, start N=5, loop=0: o_cnt_val 5,4,3,2,1,0 on consecutive cycles. o_cnt_done=1 only at 0. o_busy falls the next cycle. o_exp_cnt=1.
- Start N=3, loop=1, run 12 cycles: done pulses every 4 cycles (3 pulses). o_cnt_val sequence 3,2,1,0,3,... o_exp_cnt=3.
- Start N=10, pause 4 cycles when o_cnt_val=6: o_cnt_val holds 6 for 4 cycles, o_paused=1. Done arrives 4 cycles later than unpaused.
- Start N=8, stop at o_cnt_val=4: next cycle o_cnt_val=0, IDLE, no done pulse. Stop+start same cycle: stays IDLE.
- Start N=0: single done pulse next cycle, o_busy never asserts. Retrigger N=20 at o_cnt_val=2 of N=7: o_cnt_val=20 next cycle, o_exp_cnt cleared to 0.
- EXP_WIDTH=2, N=1, loop=1, run 20 cycles: o_exp_cnt saturates at 3. Assert i_rst mid-count: all outputs 0 next cycle.
